bus_tx_frame: RTL

BUS_TX_FRAME -- requirements
Module: bus_tx_frame

---
 rtl/bus_tx_frame.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bus_tx_frame.sv
// bus_tx_frame: builds a response frame (header, payload, checksum) into the transmit buffer
module bus_tx_frame (
    input  logic        clk,
    input  logic        reset,
    input  logic        resp_req,
    input  logic [7:0]  resp_cmd,
    input  logic [7:0]  resp_status,
    input  logic [23:0] resp_addr,
    input  logic [7:0]  resp_len,
    output logic        data_buf_rden,
    output logic [5:0]  data_buf_raddr,
    input  logic [7:0]  data_buf_rdata,
    output logic        tx_buf_wren,
    output logic [10:0] tx_buf_waddr,
    output logic [7:0]  tx_buf_wdata,
    output logic [10:0] tx_frame_len,
    output logic        tx_start,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, status_q;
    logic [23:0] addr_q;
    logic [6:0]  len_q, len_clamped;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic [7:0]  hdr_byte;
    logic        accept;

    assign accept       = (state_q == IDLE) && resp_req;
    assign len_clamped  = (resp_len > 8'd64) ? 7'd64 : resp_len[6:0];
    assign tx_buf_waddr = {4'd0, idx_q};
    assign tx_frame_len = frame_len_q;

    // State, byte index, running checksum and latched request fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            frame_len_q <= '0;
            cmd_q       <= '0;
            status_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            frame_len_q <= frame_len_d;
            if (accept) begin
                cmd_q    <= resp_cmd;
                status_q <= resp_status;
                addr_q   <= resp_addr;
                len_q    <= len_clamped;
            end
        end
    end

    // Fixed header byte selected by the current write index
    always_comb begin
        case (idx_q)
            7'd0:    hdr_byte = 8'hA5;
            7'd1:    hdr_byte = cmd_q;
            7'd2:    hdr_byte = status_q;
            7'd3:    hdr_byte = {1'b0, len_q};
            7'd6:    hdr_byte = addr_q[23:16];
            7'd7:    hdr_byte = addr_q[15:8];
            7'd8:    hdr_byte = addr_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next state and outputs; payload reads run one index ahead of writes to hide RAM latency
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        csum_d        = csum_q;
        frame_len_d   = frame_len_q;
        tx_buf_wren   = 1'b0;
        tx_buf_wdata  = 8'h00;
        data_buf_rden = 1'b0;
        tx_start      = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (resp_req) begin
                    state_d = HDR;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            HDR: begin
                tx_buf_wren   = 1'b1;
                tx_buf_wdata  = hdr_byte;
                data_buf_rden = (idx_q == 7'd8) && (len_q != 7'd0);
                idx_d         = idx_q + 7'd1;
                if (idx_q == 7'd8)
                    state_d = (len_q == 7'd0) ? CSUM : DATA;
            end
            DATA: begin
                tx_buf_wren   = 1'b1;
                tx_buf_wdata  = data_buf_rdata;
                data_buf_rden = idx_q < (7'd8 + len_q);
                idx_d         = idx_q + 7'd1;
                if (idx_q == 7'd8 + len_q)
                    state_d = CSUM;
            end
            CSUM: begin
                tx_buf_wren  = 1'b1;
                tx_buf_wdata = csum_q;
                state_d      = DONE;
                frame_len_d  = 11'(len_q) + 11'd10;
            end
            DONE: begin
                tx_start = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == HDR && idx_q != 7'd0) || state_q == DATA)
            csum_d = csum_q ^ tx_buf_wdata;
    end

    assign data_buf_raddr = data_buf_rden ? 6'(idx_q - 7'd8) : 6'd0;
endmodule
